// File: rtl/alu_dispatch.sv
// alu_dispatch: issue-side buffer placed directly upstream of ALU_top.
// Decoded ALU ops from the control unit are queued in a small FIFO and issued
// one at a time over the ALU accept/ready handshake. Each result is captured
// with its flags and destination tag and held until writeback consumes it.
// Only one op is ever outstanding in the ALU.
//
// Ports:
//   soc_clk, reset        clock (rising edge) and synchronous active-high reset
//   cu_valid/cu_ready     control-unit push handshake (cu_ready is a registered
//                         "not full" flag, forced low while reset is high)
//   cu_dat1/2, cu_instr,  operands, opcode (0 = no-op, dropped) and
//   cu_rd                 destination tag of the pushed op
//   ALU_accept            ALU captures disp_* on an edge where this is high
//   ALU_ready, ALU_out,   ALU result valid, result and flags
//   ALU_zero/overflow/con_met/err
//   disp_dat1/2,          operands and opcode presented to the ALU;
//   disp_instr            disp_instr is non-zero only while issuing
//   wb_valid/wb_ready     writeback handshake for the captured result
//   wb_data, wb_rd,       captured result, tag and flags
//   wb_zero/ovf/con_met/err
//   fifo_count            number of queued (not yet issued) ops
module alu_dispatch #(
  parameter int DEPTH   = 4,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                       soc_clk,
  input  logic                       reset,
  input  logic                       cu_valid,
  output logic                       cu_ready,
  input  logic [31:0]                cu_dat1,
  input  logic [31:0]                cu_dat2,
  input  logic [5:0]                 cu_instr,
  input  logic [RD_W-1:0]            cu_rd,
  input  logic                       ALU_accept,
  input  logic                       ALU_ready,
  input  logic [31:0]                ALU_out,
  input  logic                       ALU_zero,
  input  logic                       ALU_overflow,
  input  logic                       ALU_con_met,
  input  logic                       ALU_err,
  output logic [31:0]                disp_dat1,
  output logic [31:0]                disp_dat2,
  output logic [5:0]                 disp_instr,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [31:0]                wb_data,
  output logic [RD_W-1:0]            wb_rd,
  output logic                       wb_zero,
  output logic                       wb_ovf,
  output logic                       wb_con_met,
  output logic                       wb_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  // Wait counter only has to reach TIMEOUT-1.
  localparam int WC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [31:0]     dat1;
    logic [31:0]     dat2;
    logic [5:0]      instr;
    logic [RD_W-1:0] rd;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full_q;
  logic              push;
  logic              pop;

  state_t            state;
  logic [RD_W-1:0]   tag;
  logic [WC_W-1:0]   wait_cnt;

  // Full flag is a register, so cu_ready never sees a same-cycle pop.
  assign cu_ready = ~full_q & ~reset;
  // A no-op completes the handshake but is never stored.
  assign push     = cu_valid & cu_ready & (cu_instr != 6'd0);
  // The FSM takes the head in IDLE, or in HOLD as the writeback is consumed.
  assign pop      = (fifo_count != '0) &&
                    ((state == IDLE) || ((state == HOLD) && wb_ready));
  assign head     = mem[rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are live, so stale contents are never read.
  always_ff @(posedge soc_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{dat1: cu_dat1, dat2: cu_dat2, instr: cu_instr, rd: cu_rd};
    end
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full_q     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10: begin
          fifo_count <= fifo_count + 1'b1;
          full_q     <= (fifo_count == CNT_W'(DEPTH - 1));
        end
        2'b01: begin
          fifo_count <= fifo_count - 1'b1;
          full_q     <= 1'b0;
        end
        default: ;  // no change, including simultaneous push and pop
      endcase
    end
  end

  // NOTE: every register here is assigned with <= so all of them update
  // together from the values present before the edge.
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state      <= IDLE;
      disp_dat1  <= '0;
      disp_dat2  <= '0;
      disp_instr <= '0;
      tag        <= '0;
      wait_cnt   <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_zero    <= 1'b0;
      wb_ovf     <= 1'b0;
      wb_con_met <= 1'b0;
      wb_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            disp_dat1  <= head.dat1;
            disp_dat2  <= head.dat2;
            disp_instr <= head.instr;
            tag        <= head.rd;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Operands may linger; only the opcode marks an active issue.
          if (ALU_accept) begin
            disp_instr <= '0;
            wait_cnt   <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (ALU_ready) begin
            wb_data    <= ALU_out;
            wb_zero    <= ALU_zero;
            wb_ovf     <= ALU_overflow;
            wb_con_met <= ALU_con_met;
            wb_err     <= ALU_err;
            wb_rd      <= tag;
            wb_valid   <= 1'b1;
            state      <= HOLD;
          end else if ((TIMEOUT != 0) && (wait_cnt == WC_W'(TO_LAST))) begin
            // Forced error completion so a hung ALU cannot stall the pipe.
            wb_data    <= '0;
            wb_zero    <= 1'b0;
            wb_ovf     <= 1'b0;
            wb_con_met <= 1'b0;
            wb_err     <= 1'b1;
            wb_rd      <= tag;
            wb_valid   <= 1'b1;
            state      <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (pop) begin
              disp_dat1  <= head.dat1;
              disp_dat2  <= head.dat2;
              disp_instr <= head.instr;
              tag        <= head.rd;
              state      <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: self-checking bench for alu_dispatch. A behavioural ALU
// answers the dispatcher's handshake; a queue of expected writebacks, filled
// from the ops the control unit successfully pushed, is compared in order
// against every consumed writeback.
module tb_alu_dispatch;

  localparam int DEPTH   = 4;
  localparam int RD_W    = 5;
  localparam int TIMEOUT = 8;
  localparam int N_RAND  = 60;

  logic            soc_clk = 1'b0;
  logic            reset;
  logic            cu_valid;
  logic            cu_ready;
  logic [31:0]     cu_dat1, cu_dat2;
  logic [5:0]      cu_instr;
  logic [RD_W-1:0] cu_rd;
  logic            ALU_accept, ALU_ready;
  logic [31:0]     ALU_out;
  logic            ALU_zero, ALU_overflow, ALU_con_met, ALU_err;
  logic [31:0]     disp_dat1, disp_dat2;
  logic [5:0]      disp_instr;
  logic            wb_valid, wb_ready;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            wb_zero, wb_ovf, wb_con_met, wb_err;
  logic [2:0]      fifo_count;

  alu_dispatch #(.DEPTH(DEPTH), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .soc_clk(soc_clk), .reset(reset),
    .cu_valid(cu_valid), .cu_ready(cu_ready),
    .cu_dat1(cu_dat1), .cu_dat2(cu_dat2), .cu_instr(cu_instr), .cu_rd(cu_rd),
    .ALU_accept(ALU_accept), .ALU_ready(ALU_ready), .ALU_out(ALU_out),
    .ALU_zero(ALU_zero), .ALU_overflow(ALU_overflow),
    .ALU_con_met(ALU_con_met), .ALU_err(ALU_err),
    .disp_dat1(disp_dat1), .disp_dat2(disp_dat2), .disp_instr(disp_instr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_zero(wb_zero), .wb_ovf(wb_ovf), .wb_con_met(wb_con_met), .wb_err(wb_err),
    .fifo_count(fifo_count)
  );

  always #5 soc_clk = ~soc_clk;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic [3:0]      flags;   // {zero, ovf, con_met, err}
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_wb     = 0;
  int  alu_lat  = 2;          // >0 fixed latency, 0 random 1..4, <0 never ready

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference ALU: flags and result as a function of opcode and operands.
  function automatic logic [35:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic z, o, c, e;
    r = (op == 6'd27) ? a + b : (a ^ b) + {26'd0, op};
    z = (r == 32'd0);
    o = (op == 6'd27) && (a[31] == b[31]) && (r[31] != a[31]);
    c = (op != 6'd27) && (a < b);
    e = (op == 6'd63);
    return {z, o, c, e, r};
  endfunction

  function automatic wb_t expect_of(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [RD_W-1:0] rd);
    logic [35:0] r;
    wb_t w;
    r = alu_fn(op, a, b);
    w.rd = rd;
    if (alu_lat < 0) begin
      w.data  = 32'd0;
      w.flags = 4'b0001;
    end else begin
      w.data  = r[31:0];
      w.flags = r[35:32];
    end
    return w;
  endfunction

  // Behavioural ALU: decides at each falling edge what the next rising edge sees.
  initial begin : alu_model
    logic [31:0] cap_a, cap_b;
    logic [5:0]  cap_op;
    logic [35:0] r;
    int          remaining;
    ALU_ready = 1'b0; ALU_out = '0;
    {ALU_zero, ALU_overflow, ALU_con_met, ALU_err} = 4'b0;
    remaining = -1; cap_a = '0; cap_b = '0; cap_op = '0;
    forever begin
      @(negedge soc_clk);
      if (reset) begin
        remaining = -1; ALU_ready = 1'b0; ALU_out = '0;
        {ALU_zero, ALU_overflow, ALU_con_met, ALU_err} = 4'b0;
      end else begin
        if (ALU_ready) begin
          ALU_ready = 1'b0; ALU_out = '0; remaining = -1;
          {ALU_zero, ALU_overflow, ALU_con_met, ALU_err} = 4'b0;
        end else if (remaining > 0) begin
          remaining--;
          if (remaining == 0) begin
            r = alu_fn(cap_op, cap_a, cap_b);
            ALU_ready = 1'b1;
            ALU_out   = r[31:0];
            {ALU_zero, ALU_overflow, ALU_con_met, ALU_err} = r[35:32];
          end
        end
        if (ALU_accept && disp_instr != 6'd0) begin
          cap_a = disp_dat1; cap_b = disp_dat2; cap_op = disp_instr;
          if (alu_lat < 0)       remaining = -1;
          else if (alu_lat == 0) remaining = $urandom_range(1, 4);
          else                   remaining = alu_lat;
        end
      end
    end
  end

  // Scoreboard: every consumed writeback must match the oldest expected op.
  initial begin : monitor
    wb_t        e;
    logic [5:0] prev_instr = '0;
    logic       prev_acc   = 1'b0;
    forever begin
      @(negedge soc_clk);
      if (!reset && wb_valid && wb_ready) begin
        n_wb++;
        if (exp_q.size() == 0) begin
          check("wb_unexpected", wb_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("wb_data", wb_data, e.data);
          check("wb_rd", wb_rd, e.rd);
          check("wb_flags", {wb_zero, wb_ovf, wb_con_met, wb_err}, e.flags);
        end
      end
      if (!reset && prev_instr != 6'd0 && !prev_acc)
        check("instr_stable", disp_instr, prev_instr);
      prev_instr = reset ? 6'd0 : disp_instr;
      prev_acc   = ALU_accept;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge soc_clk);
    #1;
  endtask

  // Called at a drive point; returns just after the edge that took the op.
  task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic [RD_W-1:0] rd);
    bit took;
    took = 1'b0;
    cu_valid = 1'b1; cu_dat1 = a; cu_dat2 = b; cu_instr = op; cu_rd = rd;
    for (int i = 0; i < 200 && !took; i++) begin
      @(negedge soc_clk);
      if (cu_ready) took = 1'b1;
    end
    if (took && op != 6'd0) exp_q.push_back(expect_of(op, a, b, rd));
    if (!took) check("push_timeout", took, 1'b1);
    step();
    cu_valid = 1'b0; cu_instr = '0;
  endtask

  // Counts falling edges until wb_valid is seen; ends on that falling edge.
  task automatic wait_wb(output int n, output int acc);
    n = 0; acc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge soc_clk);
      if (ALU_accept && disp_instr != 6'd0) acc++;
      if (wb_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("wb_wait_timeout", wb_valid, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (exp_q.size() != 0 || wb_valid); i++) @(negedge soc_clk);
    check("drain_left", exp_q.size(), 0);
    step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cu_ready"}, cu_ready, 1'b1);
    check({tag, "_count"}, fifo_count, 0);
    check({tag, "_disp"}, {disp_dat1, disp_dat2, disp_instr}, 0);
    check({tag, "_wb_valid"}, wb_valid, 1'b0);
    check({tag, "_wb"}, {wb_data, wb_rd, wb_zero, wb_ovf, wb_con_met, wb_err}, 0);
  endtask

  initial begin : main
    int  n, acc, n0, bad, sent;
    bit  took;
    wb_t exp_p;
    reset = 1'b1; cu_valid = 1'b0; cu_dat1 = '0; cu_dat2 = '0; cu_instr = '0;
    cu_rd = '0; ALU_accept = 1'b0; wb_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge soc_clk);
    check("rst_cu_ready_low", cu_ready, 1'b0);
    check("rst_count", fifo_count, 0);
    step(); reset = 1'b0;
    @(negedge soc_clk);
    check_idle("post_rst");
    step();

    // Single op: ADD(10,5) op27 rd3, ALU ready two cycles after capture
    ALU_accept = 1'b1; wb_ready = 1'b1; alu_lat = 2;
    push_op(32'd10, 32'd5, 6'd27, 5'd3);
    wait_wb(n, acc);
    check("single_latency", n, 5);
    check("single_accepts", acc, 1);
    check("single_data", wb_data, 32'd15);
    check("single_rd", wb_rd, 5'd3);
    check("single_flags", {wb_zero, wb_ovf, wb_con_met, wb_err}, 4'b0);
    step(); drain();

    // Timeout: ALU never ready -> error completion after 8 WAIT edges
    alu_lat = -1;
    push_op(32'h1234, 32'h1, 6'd12, 5'd7);
    wait_wb(n, acc);
    check("timeout_latency", n, 11);
    check("timeout_err", wb_err, 1'b1);
    check("timeout_data", wb_data, 32'd0);
    step(); drain();
    alu_lat = 2;

    // Writeback backpressure for 10 cycles
    alu_lat = 1; wb_ready = 1'b0;
    exp_p = expect_of(6'd5, 32'd100, 32'd23, 5'd9);
    push_op(32'd100, 32'd23, 6'd5, 5'd9);
    push_op(32'd7, 32'd7, 6'd9, 5'd10);
    wait_wb(n, acc);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", wb_valid, 1'b1);
      check("bp_data", wb_data, exp_p.data);
      check("bp_rd", wb_rd, exp_p.rd);
      check("bp_no_issue", disp_instr, 6'd0);
      check("bp_count", fifo_count, 1);
      @(negedge soc_clk);
    end
    step(); wb_ready = 1'b1;
    @(negedge soc_clk);
    @(negedge soc_clk);
    check("bp_next_issue", disp_instr, 6'd9);
    check("bp_valid_clr", wb_valid, 1'b0);
    check("bp_count_after", fifo_count, 0);
    step(); drain();

    // Full FIFO and ordering
    ALU_accept = 1'b0; wb_ready = 1'b1; alu_lat = 2;
    n0 = n_wb;
    push_op(32'd1, 32'd2, 6'd1, 5'd20);
    step(); step();
    for (int k = 0; k < 4; k++)
      push_op(32'(k * 3), 32'(k), 6'(2 + k), 5'(11 + k));
    @(negedge soc_clk);
    check("full_count", fifo_count, 4);
    check("full_ready", cu_ready, 1'b0);
    step();
    fork
      push_op(32'hFFFF_FFFF, 32'd1, 6'd27, 5'd31);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge soc_clk);
          check("full_held", cu_ready, 1'b0);
          check("full_held_count", fifo_count, 4);
        end
        step(); ALU_accept = 1'b1;
      end
    join
    drain();
    check("full_order_count", n_wb - n0, 6);

    // No-op push, then reset while in WAIT with two ops queued
    ALU_accept = 1'b1; wb_ready = 1'b1; alu_lat = 40;
    push_op(32'd50, 32'd60, 6'd3, 5'd1);
    push_op(32'd70, 32'd80, 6'd4, 5'd2);
    push_op(32'd90, 32'd11, 6'd8, 5'd4);
    @(negedge soc_clk);
    check("noop_count_before", fifo_count, 2);
    step();
    push_op(32'd5, 32'd5, 6'd0, 5'd6);
    @(negedge soc_clk);
    check("noop_count_after", fifo_count, 2);
    step();
    reset = 1'b1; exp_q.delete();
    @(negedge soc_clk);
    check("mid_rst_cu_ready", cu_ready, 1'b0);
    step(); reset = 1'b0;
    @(negedge soc_clk);
    check_idle("mid_rst");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge soc_clk);
      if (wb_valid || disp_instr != 6'd0) bad++;
    end
    check("mid_rst_no_wb", bad, 0);
    check("mid_rst_count", fifo_count, 0);
    step();

    // Randomized traffic with random accept, writeback stalls and latencies
    alu_lat = 0; sent = 0; took = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (sent == N_RAND && exp_q.size() == 0 && !wb_valid) break;
      if (took) begin
        cu_valid = 1'b0; cu_instr = '0; took = 1'b0;
      end
      if (!cu_valid && sent < N_RAND && $urandom_range(0, 2) != 0) begin
        cu_dat1  = $urandom;
        cu_dat2  = ($urandom_range(0, 3) == 0) ? ~cu_dat1 + 32'd1 : $urandom;
        cu_instr = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        cu_rd    = 5'($urandom_range(0, 31));
        cu_valid = 1'b1;
      end
      ALU_accept = ($urandom_range(0, 3) != 0);
      wb_ready   = ($urandom_range(0, 2) != 0);
      @(negedge soc_clk);
      if (cu_valid && cu_ready) begin
        took = 1'b1;
        sent++;
        if (cu_instr != 6'd0) exp_q.push_back(expect_of(cu_instr, cu_dat1, cu_dat2, cu_rd));
      end
      step();
    end
    cu_valid = 1'b0; cu_instr = '0;
    check("rand_sent", sent, N_RAND);
    check("rand_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
